// File: rtl/data_input_pkg.sv
// Shared constants and types for the data_input port block.
// Provides the port-bus widths, the nibble/port-id types and a nibble
// extraction helper used by the read mux and the change detector.
package data_input_pkg;

  localparam int unsigned PORT_W    = 4;
  localparam int unsigned NUM_PORTS = 4;
  localparam int unsigned IN_W      = 16;

  typedef logic [1:0]        port_id_t;
  typedef logic [PORT_W-1:0] nibble_t;

  // Select nibble p of a 16-bit vector: p=0 -> [3:0] ... p=3 -> [15:12].
  function automatic nibble_t get_nibble(input logic [IN_W-1:0] v, input port_id_t p);
    return v[PORT_W*int'(p) +: PORT_W];
  endfunction

endpackage

// File: rtl/input_debounce.sv
// Vectored synchroniser + debouncer for the external switch lines.
// Ports:
//   clk, reset (async, active-low)
//   tick  - shared sample strobe from the top-level prescaler
//   raw   - asynchronous input lines
//   db    - debounced, registered level per line
// Each line takes a new level only after SAMPLES consecutive equal samples.
module input_debounce #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SAMPLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] db
);

  logic [WIDTH-1:0]              sync1;
  logic [WIDTH-1:0]              sync2;
  logic [WIDTH-1:0][SAMPLES-1:0] hist;
  logic [WIDTH-1:0][SAMPLES-1:0] hist_nxt;
  logic [WIDTH-1:0]              db_nxt;

  // Shift history on tick; the level is judged on the freshly shifted history.
  always_comb begin
    hist_nxt = hist;
    db_nxt   = db;
    if (tick) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        hist_nxt[i] = {hist[i][SAMPLES-2:0], sync2[i]};
        if (&hist_nxt[i]) begin
          db_nxt[i] = 1'b1;
        end else if (~|hist_nxt[i]) begin
          db_nxt[i] = 1'b0;
        end
      end
    end
  end

  // Two-stage synchroniser, history and debounced level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
      db    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      hist  <= hist_nxt;
      db    <= db_nxt;
    end
  end

endmodule

// File: rtl/data_input.sv
// Input-port block: debounced switches read back one nibble per rd strobe.
// Ports:
//   clk, reset (async, active-low)
//   rd       - read strobe
//   PortID   - nibble select (0: [3:0] .. 3: [15:12])
//   Switches - raw external inputs
//   Data     - registered read nibble, holds until the next read
//   Valid    - one-cycle pulse after each read
//   Changed  - sticky per-port change flags (DATA_INPUT_EDGE_EN only, else 0)
//   Irq      - OR of Changed, registered (DATA_INPUT_EDGE_EN only, else 0)
// Build option: define DATA_INPUT_EDGE_EN to include change detection.
module data_input
  import data_input_pkg::*;
#(
  parameter int unsigned DB_DIV     = 1000,
  parameter int unsigned DB_SAMPLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rd,
  input  port_id_t             PortID,
  input  logic [IN_W-1:0]      Switches,
  output nibble_t              Data,
  output logic                 Valid,
  output logic [NUM_PORTS-1:0] Changed,
  output logic                 Irq
);

  localparam int unsigned CNT_W = (DB_DIV > 1) ? $clog2(DB_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [IN_W-1:0]  db;

  // Sample prescaler; with DB_DIV=1 the count stays at 0 and tick is constant.
  assign tick = (cnt == CNT_W'(DB_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  input_debounce #(
    .WIDTH   (IN_W),
    .SAMPLES (DB_SAMPLES)
  ) u_deb (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .raw   (Switches),
    .db    (db)
  );

  // Read register: capture the selected nibble as it stands at the rd edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Data  <= '0;
      Valid <= 1'b0;
    end else begin
      Valid <= rd;
      if (rd) begin
        Data <= get_nibble(db, PortID);
      end
    end
  end

`ifdef DATA_INPUT_EDGE_EN
  logic [IN_W-1:0]      db_q;
  logic [NUM_PORTS-1:0] chg_set;
  logic [NUM_PORTS-1:0] chg_clr;
  logic [NUM_PORTS-1:0] changed_nxt;

  // Set beats clear when both hit the same flag in one cycle.
  always_comb begin
    chg_set = '0;
    chg_clr = '0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      chg_set[p] = (get_nibble(db, port_id_t'(p)) != get_nibble(db_q, port_id_t'(p)));
      chg_clr[p] = rd && (PortID == port_id_t'(p));
    end
    changed_nxt = chg_set | (Changed & ~chg_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_q    <= '0;
      Changed <= '0;
      Irq     <= 1'b0;
    end else begin
      db_q    <= db;
      Changed <= changed_nxt;
      Irq     <= |changed_nxt;
    end
  end
`else
  assign Changed = '0;
  assign Irq     = 1'b0;
`endif

endmodule

// File: tb/tb_data_input.sv
// Directed bench for data_input with DB_DIV=4, DB_SAMPLES=3.
module tb_data_input;

  logic        clk;
  logic        reset;
  logic        rd;
  logic [1:0]  PortID;
  logic [15:0] Switches;
  logic [3:0]  Data;
  logic        Valid;
  logic [3:0]  Changed;
  logic        Irq;

  int tests;
  int fails;

`ifdef DATA_INPUT_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  data_input #(
    .DB_DIV     (4),
    .DB_SAMPLES (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rd       (rd),
    .PortID   (PortID),
    .Switches (Switches),
    .Data     (Data),
    .Valid    (Valid),
    .Changed  (Changed),
    .Irq      (Irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single read: rd high for one edge; returns at the negedge after that edge.
  task automatic do_read(input logic [1:0] p);
    @(negedge clk);
    rd     = 1'b1;
    PortID = p;
    @(negedge clk);
    rd     = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] z;
    z = 4'h0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if (Data !== 4'h0 || Valid !== 1'b0 || Changed !== 4'h0 || Irq !== 1'b0) begin
      fails++;
      $display("FAIL reset_async: Data=%h Valid=%b Changed=%b Irq=%b, required all 0",
               Data, Valid, Changed, Irq);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int p = 0; p < 4; p++) begin
      do_read(2'(p));
      tests++;
      if (Data !== z || Valid !== 1'b1) begin
        fails++;
        $display("FAIL reset_read%0d: Data=%h Valid=%b, required Data=0 Valid=1", p, Data, Valid);
      end
    end
    @(negedge clk);
    tests++;
    if (Valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid_drop: Valid=%b, required 0", Valid);
    end
  endtask

  task automatic test_clean_debounce();
    logic [3:0] exp [4];
    exp = '{4'h3, 4'hC, 4'h5, 4'hA};
    @(negedge clk);
    Switches = 16'hA5C3;
    repeat (20) @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      do_read(2'(p));
      tests++;
      if (Data !== exp[p] || Valid !== 1'b1) begin
        fails++;
        $display("FAIL clean_read%0d: Data=%h Valid=%b, required Data=%h Valid=1",
                 p, Data, Valid, exp[p]);
      end
    end
  endtask

  task automatic test_glitch();
    @(negedge clk);
    Switches = 16'h0000;
    repeat (20) @(negedge clk);
    Switches[0] = 1'b1;
    repeat (6) @(negedge clk);
    Switches[0] = 1'b0;
    repeat (20) @(negedge clk);
    do_read(2'd0);
    tests++;
    if (Data !== 4'h0) begin
      fails++;
      $display("FAIL glitch_short: Data=%h, required 0", Data);
    end
    @(negedge clk);
    Switches[0] = 1'b1;
    repeat (16) @(negedge clk);
    Switches[0] = 1'b0;
    do_read(2'd0);
    tests++;
    if (Data !== 4'h1) begin
      fails++;
      $display("FAIL glitch_long: Data=%h, required 1", Data);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_latency();
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    @(negedge clk);
    Switches[4] = 1'b1;
    while (n < 40 && !seen) begin
      @(posedge clk);
      n++;
      #1;
      if (dut.db[4] === 1'b1) seen = 1'b1;
    end
    tests++;
    if (!seen || n < 11 || n > 15) begin
      fails++;
      $display("FAIL latency: db[4] rose after %0d cycles (seen=%0b), required 11..15", n, seen);
    end
  endtask

  task automatic test_change_flags();
    int n;
    bit seen;
    logic [3:0] exp_chg;
    exp_chg = EDGE ? 4'b0100 : 4'b0000;
    repeat (20) @(negedge clk);
    for (int p = 0; p < 4; p++) do_read(2'(p));
    @(negedge clk);
    tests++;
    if (Changed !== 4'b0000 || Irq !== 1'b0) begin
      fails++;
      $display("FAIL chg_cleared: Changed=%b Irq=%b, required 0000/0", Changed, Irq);
    end
    Switches[9] = 1'b1;
    repeat (20) @(negedge clk);
    tests++;
    if (Changed !== exp_chg || Irq !== EDGE) begin
      fails++;
      $display("FAIL chg_set: Changed=%b Irq=%b, required %b/%b", Changed, Irq, exp_chg, EDGE);
    end
    do_read(2'd2);
    tests++;
    if (Changed !== 4'b0000 || Irq !== 1'b0 || Data !== 4'h2) begin
      fails++;
      $display("FAIL chg_clear: Changed=%b Irq=%b Data=%h, required 0000/0/2", Changed, Irq, Data);
    end
    Switches[9] = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (n < 40 && !seen) begin
      @(negedge clk);
      n++;
      if (dut.db[9] === 1'b0) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL chg_fall_timeout: db[9]=%b after %0d cycles, required 0", dut.db[9], n);
    end
    // Read lands on the same edge the set condition is evaluated.
    rd     = 1'b1;
    PortID = 2'd2;
    @(negedge clk);
    rd = 1'b0;
    tests++;
    if (Changed !== exp_chg || Irq !== EDGE || Data !== 4'h0) begin
      fails++;
      $display("FAIL chg_set_wins: Changed=%b Irq=%b Data=%h, required %b/%b/0",
               Changed, Irq, Data, exp_chg, EDGE);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp [4];
    exp = '{4'h1, 4'h6, 4'hE, 4'h9};
    @(negedge clk);
    Switches = 16'h9E61;
    repeat (20) @(negedge clk);
    rd     = 1'b1;
    PortID = 2'd0;
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      tests++;
      if (Data !== exp[p] || Valid !== 1'b1) begin
        fails++;
        $display("FAIL b2b_read%0d: Data=%h Valid=%b, required Data=%h Valid=1",
                 p, Data, Valid, exp[p]);
      end
      if (p < 3) PortID = 2'(p + 1);
      else       rd = 1'b0;
    end
    @(negedge clk);
    tests++;
    if (Valid !== 1'b0 || Data !== 4'h9) begin
      fails++;
      $display("FAIL b2b_end: Data=%h Valid=%b, required Data=9 Valid=0", Data, Valid);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    rd     = 1'b1;
    PortID = 2'd2;
    @(posedge clk);
    #1;
    rd = 1'b0;
    tests++;
    if (Data !== 4'hE || Valid !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset: Data=%h Valid=%b, required E/1", Data, Valid);
    end
    reset = 1'b0;
    #1;
    tests++;
    if (Data !== 4'h0 || Valid !== 1'b0 || Changed !== 4'h0 || Irq !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: Data=%h Valid=%b Changed=%b Irq=%b, required all 0",
               Data, Valid, Changed, Irq);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    // Debounce restarts from scratch, so a prompt read still sees 0.
    do_read(2'd3);
    tests++;
    if (Data !== 4'h0 || Valid !== 1'b1) begin
      fails++;
      $display("FAIL post_reset_read: Data=%h Valid=%b, required 0/1", Data, Valid);
    end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    reset    = 1'b1;
    rd       = 1'b0;
    PortID   = 2'd0;
    Switches = 16'h0000;
    test_reset();
    test_clean_debounce();
    test_glitch();
    test_latency();
    test_change_flags();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
